// File: rtl/irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM encoding,
// default geometry and the fixed source index assignments.
package irq_pkg;
  localparam int NSRC_DEF   = 8;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 32;

  localparam int BP0 = 0;
  localparam int BP1 = 1;
  localparam int BP2 = 2;
  localparam int BP3 = 3;
  localparam int KBD = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
endpackage

// File: rtl/irq_arbiter_if.sv
// Source/config/CPU-side signal bundle of the interrupt arbiter.
// The slave modport is the arbiter; the master modport is whoever drives the sources and the CPU.
interface irq_arbiter_if #(
  parameter int NSRC   = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(NSRC)
);
  logic [NSRC-1:0]        srcReq;
  logic [NSRC*DATA_W-1:0] srcData;
  logic                   cfgWe;
  logic [IDX_W-1:0]       cfgIdx;
  logic [ADDR_W-1:0]      cfgVec;
  logic                   cfgEn;
  logic                   cfgClrOvr;
  logic                   turnOffIRQ;
  logic                   irq;
  logic [ADDR_W-1:0]      intAddr;
  logic [DATA_W-1:0]      intData;
  logic [IDX_W-1:0]       intSrc;
  logic [NSRC-1:0]        pending;
  logic [NSRC-1:0]        overrun;

  modport master (
    output srcReq, srcData, cfgWe, cfgIdx, cfgVec, cfgEn, cfgClrOvr, turnOffIRQ,
    input  irq, intAddr, intData, intSrc, pending, overrun
  );

  modport slave (
    input  srcReq, srcData, cfgWe, cfgIdx, cfgVec, cfgEn, cfgClrOvr, turnOffIRQ,
    output irq, intAddr, intData, intSrc, pending, overrun
  );
endinterface

// File: rtl/irq_arbiter_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins.
module irq_prio_enc #(
  parameter int NSRC  = 8,
  parameter int IDX_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  mask,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (mask[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter: per-source pending slots, fixed-priority
// delivery of one event at a time, acknowledge handshake with a one-cycle gap.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NSRC   = NSRC_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = $clog2(NSRC)
) (
  input  logic clk,
  input  logic rst,
  irq_arbiter_if.slave bus
);
  state_t state, stateNxt;
  logic [NSRC-1:0]   en, pnd, ovr;
  logic [ADDR_W-1:0] vec     [NSRC];
  logic [DATA_W-1:0] payload [NSRC];
  logic [NSRC-1:0]   eligible, reqOk, grantOh, capture, overSet, cfgHit;
  logic              anyElig, grant;
  logic [IDX_W-1:0]  selIdx;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] dataQ;
  logic [IDX_W-1:0]  srcQ;

  assign eligible = pnd & en;

  irq_prio_enc #(.NSRC(NSRC), .IDX_W(IDX_W)) u_enc (
    .mask  (eligible),
    .valid (anyElig),
    .idx   (selIdx)
  );

  always_comb begin
    stateNxt = state;
    grant    = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyElig) begin
          grant    = 1'b1;
          stateNxt = ISSUE;
        end
      end
      ISSUE:   if (bus.turnOffIRQ) stateNxt = GAP;
      GAP:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // A request in the granting cycle refills the slot instead of counting as overrun;
  // requests are qualified with the enable as it stood before this edge.
  always_comb begin
    for (int i = 0; i < NSRC; i++) cfgHit[i] = bus.cfgWe && (bus.cfgIdx == IDX_W'(i));
  end
  assign grantOh = grant ? (NSRC'(1) << selIdx) : '0;
  assign reqOk   = bus.srcReq & en;
  assign capture = reqOk & (~pnd | grantOh);
  assign overSet = reqOk & pnd & ~grantOh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en  <= '0;
      pnd <= '0;
      ovr <= '0;
      for (int i = 0; i < NSRC; i++) vec[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (capture[i])      pnd[i] <= 1'b1;
        else if (grantOh[i]) pnd[i] <= 1'b0;
        if (overSet[i])                       ovr[i] <= 1'b1;
        else if (cfgHit[i] && bus.cfgClrOvr) ovr[i] <= 1'b0;
        if (cfgHit[i]) begin
          en[i]  <= bus.cfgEn;
          vec[i] <= bus.cfgVec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (capture[i]) payload[i] <= bus.srcData[i*DATA_W +: DATA_W];
    end
  end

  // Delivered vector is latched at grant and held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrQ <= '0;
      dataQ <= '0;
      srcQ  <= '0;
    end else if (grant) begin
      addrQ <= vec[selIdx];
      dataQ <= payload[selIdx];
      srcQ  <= selIdx;
    end
  end

  assign bus.irq     = (state == ISSUE);
  assign bus.intAddr = addrQ;
  assign bus.intData = dataQ;
  assign bus.intSrc  = srcQ;
  assign bus.pending = pnd;
  assign bus.overrun = ovr;
endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Multi-source interrupt arbiter placed between the event sources (four breakpoint comparators, the PS/2 keyboard reader, future timers) and the CPU interrupt input. Each source latches its request and payload into its own pending slot, so an event arriving while the CPU is busy is held, not dropped. A fixed-priority scheduler delivers one pending event at a time as irq/intAddr/intData and waits for the CPU acknowledge before issuing the next. Vector addresses and enables are programmed through a small configuration port driven by the memory-mapped register decoder.

## Interface
- NSRC, 8, number of interrupt sources (2..16); index 0 is highest priority
- DATA_W, 16, payload width per source
- ADDR_W, 32, vector address width
- IDX_W, $clog2(NSRC), source index width (derived)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- srcReq  in  NSRC  per-source request pulse, sampled each clk edge
- srcData  in  NSRC*DATA_W  per-source payload; slice i belongs to source i
- cfgWe  in  1  configuration write strobe
- cfgIdx  in  IDX_W  source index being configured
- cfgVec  in  ADDR_W  vector address for cfgIdx
- cfgEn  in  1  enable bit for cfgIdx
- cfgClrOvr  in  1  with cfgWe: clear overrun flag of cfgIdx
- turnOffIRQ  in  1  CPU acknowledge of the delivered interrupt
- irq  out  1  interrupt request to CPU
- intAddr  out  ADDR_W  vector of the delivered source
- intData  out  DATA_W  payload of the delivered source
- intSrc  out  IDX_W  index of the delivered source
- pending  out  NSRC  pending flags (status readback)
- overrun  out  NSRC  sticky overrun flags (status readback)

## Operation
- Per source i: enable en[i], vector vec[i], pending pnd[i], payload buf[i], overrun ovr[i].
- srcReq[i] with en[i]=0: ignored entirely.
- srcReq[i] with en[i]=1 and pnd[i]=0: pnd[i]<=1, buf[i]<=srcData[i].
- srcReq[i] with en[i]=1 and pnd[i]=1: ovr[i]<=1; buf[i] keeps the first payload.
- Clearing en[i] leaves pnd[i] set but masks it from arbitration; re-enabling makes it eligible again.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if any pnd[i]&en[i], take the lowest such i; register irq<=1, intAddr<=vec[i], intData<=buf[i], intSrc<=i, clear pnd[i]; go to ISSUE. Otherwise stay.
  - ISSUE: hold irq and outputs stable; on turnOffIRQ: irq<=0, go to GAP.
  - GAP: one cycle with irq=0; go to IDLE.
- A srcReq[i] arriving in the same cycle as source i's grant re-sets pnd[i] with the new payload; no overrun.
- A cfgWe to index i in the same cycle as srcReq[i]: both take effect; the enable used to qualify the request is the old en[i].
- turnOffIRQ outside ISSUE: ignored.
- cfgClrOvr with srcReq overrun on the same index: set wins.

## Timing
- Reset values: irq=0, intAddr=0, intData=0, intSrc=0, pending=0, overrun=0; all en=0, all vec=0; FSM=IDLE.
- srcReq at edge N -> pnd visible after edge N -> irq high after edge N+1 (2-cycle latency from idle).
- Ack sampled at edge M while in ISSUE -> irq low after M; the next grant is at M+2 at the earliest, so irq is low for at least one full cycle between deliveries.
- Outputs stay constant for the whole time irq=1.
- Reset asserted mid-delivery: irq drops immediately (asynchronous); all pending events are discarded.

## Structure
- Package irq_pkg: state enum {IDLE, ISSUE, GAP}, default NSRC/DATA_W/ADDR_W, and the source index constants BP0..BP3=0..3, KBD=4.
- Sub-module irq_prio_enc: combinational lowest-index-first encoder (NSRC mask in -> valid plus index out).
- Register file for vec/en/buf is inline; no RAM.

## Test plan
- Enable src 4 with vec=0x100, pulse srcReq[4] with data 0x01C -> irq=1 two cycles later, intAddr=0x100, intData=0x01C, intSrc=4; ack -> irq=0 the next cycle.
- Enable src 1 and src 3, pulse both together -> src 1 is delivered first; after ack and one GAP cycle, src 3 is delivered.
- Pulse src 2 twice (data 0xA, then 0xB) before it is granted -> one delivery with intData=0xA, overrun[2]=1; cfgClrOvr clears the flag.
- Pulse srcReq[5] with en[5]=0 -> no irq and pending[5]=0; pulse with en[5]=1 and then clear en -> pending[5] is held and no irq; re-enable -> delivered.
- Hold turnOffIRQ=1 continuously with 3 sources pending -> deliveries are separated by at least one cycle with irq low, in priority order.
- Assert rst during ISSUE -> irq is 0 immediately and pending=0; no delivery after reset is released.
